// File: rtl/ddr3_ui_arbiter.sv
// ddr3_ui_arbiter
//   Shares the DDR3 MIG user interface between one write requester and one
//   read requester. Whole transactions are granted round-robin and each is cut
//   into 2-word commands (BL8 x8 on a 32-bit UI). An odd word count is padded
//   with one masked write beat, or with one discarded read word.
// Ports
//   ui_clk, ui_clk_sync_rst     : clock, synchronous active-high reset
//   init_calib_complete         : no new grant while low
//   wr_req/addr/count, wr_ack   : write request (level) and latch pulse
//   rd_req/addr/count, rd_ack   : read request (level) and latch pulse
//   wr_done, rd_done            : one-cycle completion pulses
//   wr_data, wr_stb             : write source word and its pop strobe
//   rd_data, rd_stb             : returned read word (registered) and valid
//   busy                        : a transaction is in progress
//   app_*                       : MIG command, write-data and read-data channels
module ddr3_ui_arbiter #(
  parameter int MEM_ADDR_DEPTH = 28,
  parameter int RD_OUTSTANDING = 16
) (
  input  logic                      ui_clk,
  input  logic                      ui_clk_sync_rst,
  input  logic                      init_calib_complete,
  input  logic                      wr_req,
  input  logic [MEM_ADDR_DEPTH-1:0] wr_addr,
  input  logic [23:0]               wr_count,
  output logic                      wr_ack,
  output logic                      wr_done,
  input  logic [31:0]               wr_data,
  output logic                      wr_stb,
  input  logic                      rd_req,
  input  logic [MEM_ADDR_DEPTH-1:0] rd_addr,
  input  logic [23:0]               rd_count,
  output logic                      rd_ack,
  output logic                      rd_done,
  output logic [31:0]               rd_data,
  output logic                      rd_stb,
  output logic                      busy,
  output logic [MEM_ADDR_DEPTH-1:0] app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [31:0]               app_wdf_data,
  output logic                      app_wdf_end,
  output logic [3:0]                app_wdf_mask,
  output logic                      app_wdf_wren,
  input  logic                      app_wdf_rdy,
  input  logic [31:0]               app_rd_data,
  input  logic                      app_rd_data_end,
  input  logic                      app_rd_data_valid
);

  localparam int OW = $clog2(RD_OUTSTANDING + 1);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      last_rd_q, last_rd_d;   // last grant went to the reader
  logic                      cur_rd_q, cur_rd_d;     // current transaction is a read
  logic [MEM_ADDR_DEPTH-1:0] addr_q, addr_d;
  logic [23:0]               cmds_left_q, cmds_left_d;
  logic [24:0]               beats_left_q, beats_left_d;  // UI beats incl. pad
  logic [23:0]               words_left_q, words_left_d;  // real words, excl. pad
  logic [OW-1:0]             outs_q, outs_d;
  logic                      wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic                      wr_done_q, wr_done_d, rd_done_q, rd_done_d;
  logic                      rd_stb_q, rd_stb_d;
  logic [31:0]               rd_data_q, rd_data_d;

  logic                      grant_s, grant_rd_s, rd_room_s, wr_window_s;
  logic                      cmd_fire_s, beat_fire_s, rd_beat_s;
  logic [23:0]               req_count_s, req_cmds_s;
  logic [MEM_ADDR_DEPTH-1:0] req_addr_s;
  logic                      unused_rd_end_s;

  // The data-end marker carries no information beyond the beat count.
  assign unused_rd_end_s = app_rd_data_end;

  assign grant_s     = init_calib_complete && (state_q == S_IDLE) && (wr_req || rd_req);
  assign grant_rd_s  = (wr_req && rd_req) ? !last_rd_q : rd_req;
  assign req_count_s = grant_rd_s ? rd_count : wr_count;
  assign req_addr_s  = grant_rd_s ? rd_addr : wr_addr;
  // ceil(count/2) without overflowing 24 bits at count = 2^24-1
  assign req_cmds_s  = {1'b0, req_count_s[23:1]} + {23'd0, req_count_s[0]};

  // A read command reserves room for both of its returned words up front.
  assign rd_room_s   = ({1'b0, outs_q} + (OW+1)'(2)) <= (OW+1)'(RD_OUTSTANDING);
  // beats_sent < 2*cmds_issued + 2, rewritten on the remaining counts
  assign wr_window_s = ({1'b0, beats_left_q} + 26'd2) > {1'b0, cmds_left_q, 1'b0};

  assign app_en       = (cmds_left_q != 24'd0) &&
                        ((state_q == S_WRITE) || ((state_q == S_READ) && rd_room_s));
  assign app_cmd      = cur_rd_q ? CMD_RD : CMD_WR;
  assign app_addr     = addr_q;
  assign app_wdf_wren = (state_q == S_WRITE) && (beats_left_q != 25'd0) && wr_window_s;
  // Total beats are even, so an odd remaining count means an odd beat index.
  assign app_wdf_end  = app_wdf_wren && beats_left_q[0];
  assign app_wdf_mask = (app_wdf_wren && (words_left_q == 24'd0)) ? 4'hF : 4'h0;
  assign app_wdf_data = wr_data;

  assign cmd_fire_s  = app_en && app_rdy;
  assign beat_fire_s = app_wdf_wren && app_wdf_rdy;
  assign rd_beat_s   = (state_q == S_READ) && app_rd_data_valid;
  assign wr_stb      = beat_fire_s && (words_left_q != 24'd0);

  assign busy    = (state_q != S_IDLE);
  assign wr_ack  = wr_ack_q;
  assign rd_ack  = rd_ack_q;
  assign wr_done = wr_done_q;
  assign rd_done = rd_done_q;
  assign rd_stb  = rd_stb_q;
  assign rd_data = rd_data_q;

  // State register and all registered outputs.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q      <= S_IDLE;
      last_rd_q    <= 1'b1;
      cur_rd_q     <= 1'b0;
      addr_q       <= '0;
      cmds_left_q  <= 24'd0;
      beats_left_q <= 25'd0;
      words_left_q <= 24'd0;
      outs_q       <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_stb_q     <= 1'b0;
      rd_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_rd_q    <= last_rd_d;
      cur_rd_q     <= cur_rd_d;
      addr_q       <= addr_d;
      cmds_left_q  <= cmds_left_d;
      beats_left_q <= beats_left_d;
      words_left_q <= words_left_d;
      outs_q       <= outs_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      rd_stb_q     <= rd_stb_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Next-state logic: grant, command/beat sequencing, read return.
  always_comb begin
    state_d      = state_q;
    last_rd_d    = last_rd_q;
    cur_rd_d     = cur_rd_q;
    addr_d       = addr_q;
    cmds_left_d  = cmds_left_q;
    beats_left_d = beats_left_q;
    words_left_d = words_left_q;
    outs_d       = outs_q;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    wr_done_d    = 1'b0;
    rd_done_d    = 1'b0;
    rd_stb_d     = 1'b0;
    rd_data_d    = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          cur_rd_d     = grant_rd_s;
          addr_d       = req_addr_s;
          cmds_left_d  = req_cmds_s;
          beats_left_d = {req_cmds_s, 1'b0};
          words_left_d = req_count_s;
          outs_d       = '0;
          wr_ack_d     = !grant_rd_s;
          rd_ack_d     = grant_rd_s;
          if (req_count_s == 24'd0) begin
            state_d   = S_DONE;
            wr_done_d = !grant_rd_s;
            rd_done_d = grant_rd_s;
          end else begin
            state_d = grant_rd_s ? S_READ : S_WRITE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        if (cmd_fire_s) begin
          addr_d      = addr_q + MEM_ADDR_DEPTH'(8);
          cmds_left_d = cmds_left_q - 24'd1;
        end else begin
          addr_d = addr_q;
        end
        if (beat_fire_s) begin
          beats_left_d = beats_left_q - 25'd1;
          words_left_d = (words_left_q != 24'd0) ? (words_left_q - 24'd1) : 24'd0;
        end else begin
          beats_left_d = beats_left_q;
        end
        if ((cmds_left_q == 24'd0) && (beats_left_q == 25'd0)) begin
          state_d   = S_DONE;
          wr_done_d = 1'b1;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_READ: begin
        if (cmd_fire_s) begin
          addr_d      = addr_q + MEM_ADDR_DEPTH'(8);
          cmds_left_d = cmds_left_q - 24'd1;
        end else begin
          addr_d = addr_q;
        end
        case ({cmd_fire_s, rd_beat_s})
          2'b10:   outs_d = outs_q + OW'(2);
          2'b01:   outs_d = (outs_q != '0) ? (outs_q - OW'(1)) : outs_q;
          2'b11:   outs_d = outs_q + OW'(1);
          default: outs_d = outs_q;
        endcase
        if (rd_beat_s) begin
          beats_left_d = (beats_left_q != 25'd0) ? (beats_left_q - 25'd1) : 25'd0;
          if (words_left_q != 24'd0) begin
            words_left_d = words_left_q - 24'd1;
            rd_stb_d     = 1'b1;
            rd_data_d    = app_rd_data;
          end else begin
            words_left_d = words_left_q;   // pad word: consumed, not forwarded
          end
        end else begin
          beats_left_d = beats_left_q;
        end
        if ((cmds_left_q == 24'd0) && (beats_left_q == 25'd0)) begin
          state_d   = S_DONE;
          rd_done_d = 1'b1;
        end else begin
          state_d = S_READ;
        end
      end

      S_DONE: begin
        last_rd_d = cur_rd_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
